// File: rtl/elevator_pkg.sv
// Shared elevator types: floor codes, dispatcher state encoding and floor helpers.
package elevator_pkg;

  localparam int NUM_FLOORS = 5;
  localparam int FLOOR_W    = 3;

  localparam logic [FLOOR_W-1:0] FLOOR_1 = 3'd1;
  localparam logic [FLOOR_W-1:0] FLOOR_2 = 3'd2;
  localparam logic [FLOOR_W-1:0] FLOOR_3 = 3'd3;
  localparam logic [FLOOR_W-1:0] FLOOR_4 = 3'd4;
  localparam logic [FLOOR_W-1:0] FLOOR_5 = 3'd5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OFFER  = 2'd2
  } disp_state_e;

  function automatic logic floor_valid(input logic [FLOOR_W-1:0] code);
    return (code >= FLOOR_1) && (code <= FLOOR_5);
  endfunction

  // Floor code 1..5 maps to bit index 0..4.
  function automatic logic [FLOOR_W-1:0] floor_to_idx(input logic [FLOOR_W-1:0] code);
    return code - 3'd1;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [FLOOR_W-1:0] code);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    if (floor_valid(code)) m = 5'(1) << floor_to_idx(code);
    return m;
  endfunction

endpackage

// File: rtl/hall_call_latch.sv
// Pending hall-call lamp registers; car arrivals clear a floor before new presses are merged.
module hall_call_latch
  import elevator_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_up,
  input  logic [NUM_FLOORS-1:0] call_dn,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic                  car0_done,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car1_done,
  output logic [NUM_FLOORS-1:0] lamp_up,
  output logic [NUM_FLOORS-1:0] lamp_dn,
  output logic [NUM_FLOORS-1:0] clr_mask
);

  // Top floor has no up button, bottom floor has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = 5'b01111;
  localparam logic [NUM_FLOORS-1:0] DN_MASK = 5'b11110;

  logic [NUM_FLOORS-1:0] lamp_up_q, lamp_up_d;
  logic [NUM_FLOORS-1:0] lamp_dn_q, lamp_dn_d;

  always_comb begin
    clr_mask = '0;
    if (car0_done) clr_mask = clr_mask | floor_mask(car0_floor);
    if (car1_done) clr_mask = clr_mask | floor_mask(car1_floor);
    lamp_up_d = (lamp_up_q & ~clr_mask) | (call_up & UP_MASK);
    lamp_dn_d = (lamp_dn_q & ~clr_mask) | (call_dn & DN_MASK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lamp_up_q <= '0;
      lamp_dn_q <= '0;
    end else begin
      lamp_up_q <= lamp_up_d;
      lamp_dn_q <= lamp_dn_d;
    end
  end

  assign lamp_up = lamp_up_q;
  assign lamp_dn = lamp_dn_q;

endmodule

// File: rtl/hall_call_dispatcher.sv
// Hall-call dispatcher: round-robin floor pick, nearest-idle-car choice, one offer in flight.
// Offer handshake: carN_req_valid/carN_req_floor stay stable until an edge with valid&ready
// (transfer), a timeout, or the offered floor being cleared; only one car is offered at a time.
module hall_call_dispatcher
  import elevator_pkg::*;
#(
  parameter int OFFER_TIMEOUT = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_up,
  input  logic [NUM_FLOORS-1:0] call_dn,
  input  logic [FLOOR_W-1:0]    car0_floor,
  input  logic                  car0_busy,
  output logic                  car0_req_valid,
  output logic [FLOOR_W-1:0]    car0_req_floor,
  input  logic                  car0_req_ready,
  input  logic                  car0_done,
  input  logic [FLOOR_W-1:0]    car1_floor,
  input  logic                  car1_busy,
  output logic                  car1_req_valid,
  output logic [FLOOR_W-1:0]    car1_req_floor,
  input  logic                  car1_req_ready,
  input  logic                  car1_done,
  output logic [NUM_FLOORS-1:0] lamp_up,
  output logic [NUM_FLOORS-1:0] lamp_dn,
  output logic                  timeout_err,
  output disp_state_e           dbg_state
);

  localparam logic [7:0] TMO_LAST = 8'(OFFER_TIMEOUT - 1);

  disp_state_e           state_q, state_d;
  logic [2:0]            scan_ptr_q, scan_ptr_d;
  logic [NUM_FLOORS-1:0] assigned_q, assigned_d;
  logic [FLOOR_W-1:0]    req_floor_q, req_floor_d;
  logic                  valid0_q, valid0_d;
  logic                  valid1_q, valid1_d;
  logic [7:0]            tmo_q, tmo_d;
  logic                  timeout_q, timeout_d;

  logic [NUM_FLOORS-1:0] clr_mask;
  logic [NUM_FLOORS-1:0] eligible;
  logic [NUM_FLOORS-1:0] assign_set;
  logic                  sel_found;
  logic [2:0]            sel_idx;
  logic [FLOOR_W-1:0]    sel_code;
  logic [FLOOR_W-1:0]    dist0, dist1;
  logic                  car0_ok, car1_ok, pick1;
  logic                  offer_ready;
  logic [2:0]            offer_idx;

  hall_call_latch u_latch (
    .clock      (clock),
    .reset      (reset),
    .call_up    (call_up),
    .call_dn    (call_dn),
    .car0_floor (car0_floor),
    .car0_done  (car0_done),
    .car1_floor (car1_floor),
    .car1_done  (car1_done),
    .lamp_up    (lamp_up),
    .lamp_dn    (lamp_dn),
    .clr_mask   (clr_mask)
  );

  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off);
    logic [3:0] s;
    s = {1'b0, base} + {1'b0, off};
    return (s >= 4'd5) ? 3'(s - 4'd5) : s[2:0];
  endfunction

  always_comb begin
    eligible  = (lamp_up | lamp_dn) & ~assigned_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (!sel_found && eligible[wrap_add(scan_ptr_q, 3'(i))]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(scan_ptr_q, 3'(i));
      end
    end
    sel_code = sel_idx + 3'd1;
    dist0    = (car0_floor > sel_code) ? car0_floor - sel_code : sel_code - car0_floor;
    dist1    = (car1_floor > sel_code) ? car1_floor - sel_code : sel_code - car1_floor;
    car0_ok  = !car0_busy && floor_valid(car0_floor);
    car1_ok  = !car1_busy && floor_valid(car1_floor);
    // Car 1 wins only when strictly closer; ties go to car 0.
    pick1    = car1_ok && (!car0_ok || (dist1 < dist0));
  end

  assign offer_ready = (valid0_q && car0_req_ready) || (valid1_q && car1_req_ready);
  assign offer_idx   = floor_to_idx(req_floor_q);

  always_comb begin
    state_d     = state_q;
    scan_ptr_d  = scan_ptr_q;
    req_floor_d = req_floor_q;
    valid0_d    = valid0_q;
    valid1_d    = valid1_q;
    tmo_d       = tmo_q;
    timeout_d   = 1'b0;
    assign_set  = '0;
    case (state_q)
      IDLE: begin
        if (|eligible) state_d = SELECT;
      end
      SELECT: begin
        if (!sel_found) begin
          state_d = IDLE;
        end else if (car0_ok || car1_ok) begin
          req_floor_d = sel_code;
          valid0_d    = !pick1;
          valid1_d    = pick1;
          tmo_d       = '0;
          state_d     = OFFER;
        end
      end
      OFFER: begin
        if (offer_ready) begin
          assign_set = 5'(1) << offer_idx;
          scan_ptr_d = wrap_add(offer_idx, 3'd1);
          valid0_d   = 1'b0;
          valid1_d   = 1'b0;
          state_d    = IDLE;
        end else if (clr_mask[offer_idx]) begin
          valid0_d = 1'b0;
          valid1_d = 1'b0;
          state_d  = SELECT;
        end else if (tmo_q == TMO_LAST) begin
          valid0_d  = 1'b0;
          valid1_d  = 1'b0;
          timeout_d = 1'b1;
          state_d   = SELECT;
        end else if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An arrival on the offered floor wins over a same-edge acceptance.
    assigned_d = (assigned_q | assign_set) & ~clr_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      scan_ptr_q  <= '0;
      assigned_q  <= '0;
      req_floor_q <= '0;
      valid0_q    <= 1'b0;
      valid1_q    <= 1'b0;
      tmo_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      scan_ptr_q  <= scan_ptr_d;
      assigned_q  <= assigned_d;
      req_floor_q <= req_floor_d;
      valid0_q    <= valid0_d;
      valid1_q    <= valid1_d;
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
    end
  end

  assign car0_req_valid = valid0_q;
  assign car1_req_valid = valid1_q;
  assign car0_req_floor = valid0_q ? req_floor_q : '0;
  assign car1_req_floor = valid1_q ? req_floor_q : '0;
  assign timeout_err    = timeout_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Directed bench for hall_call_dispatcher: latching, car choice, starvation, timeout, round robin, reset.
module tb_hall_call_dispatcher;
  import elevator_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  call_up, call_dn;
  logic [2:0]  car0_floor, car1_floor;
  logic        car0_busy, car1_busy;
  logic        car0_req_valid, car1_req_valid;
  logic [2:0]  car0_req_floor, car1_req_floor;
  logic        car0_req_ready, car1_req_ready;
  logic        car0_done, car1_done;
  logic [4:0]  lamp_up, lamp_dn;
  logic        timeout_err;
  disp_state_e dbg_state;

  int checks   = 0;
  int failures = 0;

  hall_call_dispatcher dut (
    .clock          (clock),
    .reset          (reset),
    .call_up        (call_up),
    .call_dn        (call_dn),
    .car0_floor     (car0_floor),
    .car0_busy      (car0_busy),
    .car0_req_valid (car0_req_valid),
    .car0_req_floor (car0_req_floor),
    .car0_req_ready (car0_req_ready),
    .car0_done      (car0_done),
    .car1_floor     (car1_floor),
    .car1_busy      (car1_busy),
    .car1_req_valid (car1_req_valid),
    .car1_req_floor (car1_req_floor),
    .car1_req_ready (car1_req_ready),
    .car1_done      (car1_done),
    .lamp_up        (lamp_up),
    .lamp_dn        (lamp_dn),
    .timeout_err    (timeout_err),
    .dbg_state      (dbg_state)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic press(input logic [4:0] up, input logic [4:0] dn);
    call_up = up;
    call_dn = dn;
    step();
    call_up = '0;
    call_dn = '0;
  endtask

  task automatic accept(input int car);
    if (car == 0) car0_req_ready = 1'b1; else car1_req_ready = 1'b1;
    step();
    car0_req_ready = 1'b0;
    car1_req_ready = 1'b0;
  endtask

  task automatic arrive(input int car, input logic [2:0] fl);
    if (car == 0) begin
      car0_floor = fl; car0_done = 1'b1;
    end else begin
      car1_floor = fl; car1_done = 1'b1;
    end
    step();
    car0_done = 1'b0;
    car1_done = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_v0"},   32'(car0_req_valid), 32'd0);
    check({tag, "_v1"},   32'(car1_req_valid), 32'd0);
    check({tag, "_lup"},  32'(lamp_up),        32'd0);
    check({tag, "_ldn"},  32'(lamp_dn),        32'd0);
    check({tag, "_tmo"},  32'(timeout_err),    32'd0);
    check({tag, "_st"},   32'(dbg_state),      32'(IDLE));
  endtask

  // Exclusivity is checked on every falling edge.
  always @(negedge clock) begin
    check("excl", 32'(car0_req_valid && car1_req_valid), 32'd0);
  end

  initial begin
    reset = 1'b1;
    call_up = '0; call_dn = '0;
    car0_floor = 3'd1; car1_floor = 3'd5;
    car0_busy = 1'b0; car1_busy = 1'b0;
    car0_req_ready = 1'b0; car1_req_ready = 1'b0;
    car0_done = 1'b0; car1_done = 1'b0;
    step(); step();
    reset = 1'b0;
    check_idle_outputs("rst");

    // Nonexistent buttons are ignored.
    press(5'b10000, 5'b00001);
    step();
    check("ghost_lup", 32'(lamp_up), 32'd0);
    check("ghost_ldn", 32'(lamp_dn), 32'd0);
    check("ghost_st",  32'(dbg_state), 32'(IDLE));

    // Single call: up at floor 2.
    press(5'b00010, 5'b00000);
    check("t1_lamp",  32'(lamp_up),   32'b00010);
    check("t1_st0",   32'(dbg_state), 32'(IDLE));
    step();
    check("t1_sel",   32'(dbg_state), 32'(SELECT));
    check("t1_nov",   32'(car0_req_valid), 32'd0);
    step();
    check("t1_v0",    32'(car0_req_valid), 32'd1);
    check("t1_f0",    32'(car0_req_floor), 32'd2);
    check("t1_v1",    32'(car1_req_valid), 32'd0);
    step();
    check("t1_hold",  32'(car0_req_valid), 32'd1);
    check("t1_holdf", 32'(car0_req_floor), 32'd2);
    accept(0);
    check("t1_drop",  32'(car0_req_valid), 32'd0);
    check("t1_idle",  32'(dbg_state),      32'(IDLE));
    check("t1_keep",  32'(lamp_up),        32'b00010);
    step();
    check("t1_asg",   32'(dbg_state),      32'(IDLE));
    arrive(0, 3'd7);
    check("t1_badfl", 32'(lamp_up),        32'b00010);
    arrive(0, 3'd2);
    check("t1_clr",   32'(lamp_up),        32'd0);
    car0_floor = 3'd1;

    // Tie goes to car 0: floor 3 with cars at 1 and 5.
    press(5'b00000, 5'b00100);
    check("t2_ldn",   32'(lamp_dn), 32'b00100);
    step(); step();
    check("t2_v0",    32'(car0_req_valid), 32'd1);
    check("t2_f0",    32'(car0_req_floor), 32'd3);
    check("t2_v1",    32'(car1_req_valid), 32'd0);
    accept(0);
    arrive(0, 3'd3);
    check("t2_clr",   32'(lamp_dn), 32'd0);
    // Nearest car: floor 4 with cars at 2 and 5 goes to car 1.
    car0_floor = 3'd2;
    press(5'b00000, 5'b01000);
    step(); step();
    check("t2_v1b",   32'(car1_req_valid), 32'd1);
    check("t2_f1b",   32'(car1_req_floor), 32'd4);
    check("t2_v0b",   32'(car0_req_valid), 32'd0);
    accept(1);
    arrive(1, 3'd4);
    car1_floor = 3'd5;

    // No idle car: both busy, floor 1 waits in SELECT.
    car0_busy = 1'b1; car1_busy = 1'b1;
    press(5'b00001, 5'b00000);
    step(); step();
    check("t3_sel",   32'(dbg_state), 32'(SELECT));
    check("t3_nov",   32'(car0_req_valid | car1_req_valid), 32'd0);
    step();
    check("t3_sel2",  32'(dbg_state), 32'(SELECT));
    car1_busy = 1'b0;
    step();
    check("t3_v1",    32'(car1_req_valid), 32'd1);
    check("t3_f1",    32'(car1_req_floor), 32'd1);
    check("t3_v0",    32'(car0_req_valid), 32'd0);
    accept(1);
    arrive(1, 3'd1);
    car1_floor = 3'd5; car0_busy = 1'b0; car0_floor = 3'd1;

    // Timeout: offer held 255 cycles, withdrawn, then re-offered.
    press(5'b00010, 5'b00000);
    step(); step();
    check("t4_v0",    32'(car0_req_valid), 32'd1);
    for (int i = 0; i < 254; i++) step();
    check("t4_v254",  32'(car0_req_valid), 32'd1);
    check("t4_nt254", 32'(timeout_err),    32'd0);
    step();
    check("t4_drop",  32'(car0_req_valid), 32'd0);
    check("t4_terr",  32'(timeout_err),    32'd1);
    check("t4_sel",   32'(dbg_state),      32'(SELECT));
    check("t4_lamp",  32'(lamp_up),        32'b00010);
    step();
    check("t4_terr0", 32'(timeout_err),    32'd0);
    check("t4_re_v",  32'(car0_req_valid), 32'd1);
    check("t4_re_f",  32'(car0_req_floor), 32'd2);
    accept(0);
    arrive(0, 3'd2);
    car0_floor = 3'd1;

    // Round robin from a fresh scan pointer: floors 1, 3, 5.
    reset = 1'b1; step(); reset = 1'b0;
    press(5'b00101, 5'b10000);
    check("t5_lup",   32'(lamp_up), 32'b00101);
    check("t5_ldn",   32'(lamp_dn), 32'b10000);
    step(); step();
    check("t5_o1f",   32'(car0_req_floor), 32'd1);
    check("t5_o1v",   32'(car0_req_valid), 32'd1);
    accept(0);
    step(); step();
    check("t5_o3f",   32'(car0_req_floor), 32'd3);
    check("t5_o3v",   32'(car0_req_valid), 32'd1);
    // Car 1 arrives at floor 3 while it is pressed again.
    car1_floor = 3'd3; car1_done = 1'b1; call_up = 5'b00100;
    step();
    car1_floor = 3'd5; car1_done = 1'b0; call_up = '0;
    check("t5_wlamp", 32'(lamp_up),        32'b00101);
    check("t5_wdrop", 32'(car0_req_valid), 32'd0);
    check("t5_wsel",  32'(dbg_state),      32'(SELECT));
    check("t5_wnt",   32'(timeout_err),    32'd0);
    step();
    check("t5_re3v",  32'(car0_req_valid), 32'd1);
    check("t5_re3f",  32'(car0_req_floor), 32'd3);
    accept(0);
    step(); step();
    check("t5_o5v",   32'(car1_req_valid), 32'd1);
    check("t5_o5f",   32'(car1_req_floor), 32'd5);
    check("t5_o5n0",  32'(car0_req_valid), 32'd0);

    // Reset during OFFER drops everything.
    reset = 1'b1; step(); reset = 1'b0;
    check_idle_outputs("rst_mid");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hall_call_dispatcher.md
Name: hall_call_dispatcher

Overview:
- Central scheduler between the hall-call buttons and two elevator car controllers.
- Latches up/down hall calls per floor and lights the hall lamps.
- Picks one unassigned call at a time and offers it to the nearest idle car over a valid/ready handshake.
- Clears a call when the serving car reports arrival at that floor.

Parameters:
- NUM_FLOORS, 5, number of floors; fixed at 5 for this release.
- FLOOR_W, 3, width of floor codes; floors are encoded 1..5, same as the car floor_number output.
- OFFER_TIMEOUT, 255, cycles an offer may wait for ready before it is withdrawn.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- call_up  in  5  hall up buttons, bit i = floor i+1, level-sampled every cycle; bit 4 ignored.
- call_dn  in  5  hall down buttons, same encoding; bit 0 ignored.
- car0_floor  in  3  current floor code of car 0 (1..5).
- car0_busy  in  1  car 0 moving or serving; 1 = not eligible for a new offer.
- car0_req_valid  out  1  offer to car 0 valid.
- car0_req_floor  out  3  floor code offered to car 0.
- car0_req_ready  in  1  car 0 accepts the offer.
- car0_done  in  1  one-cycle pulse: car 0 stopped at car0_floor with doors open.
- car1_floor, car1_busy, car1_req_valid, car1_req_floor, car1_req_ready, car1_done: same as car 0, for car 1.
- lamp_up  out  5  pending up calls.
- lamp_dn  out  5  pending down calls.
- timeout_err  out  1  one-cycle pulse when an offer is withdrawn.

Behaviour:
- **Reset values:** all outputs 0; pending, assigned and scan_ptr cleared; FSM = IDLE.
- **Latching:** a button sampled high at edge k sets its pending bit; the lamp is high after edge k. Pressing an already-pending call has no effect. call_up[4] and call_dn[0] are permanently 0.
- **Floor state:**
  - floor_pend[i] = lamp_up[i] OR lamp_dn[i].
  - assigned[i] set when an offer for floor i+1 is accepted.
  - A floor is eligible when floor_pend=1 and assigned=0.
- **Clearing:** carN_done at edge k clears lamp_up, lamp_dn and assigned for floor carN_floor. If carN_floor is invalid, done is ignored.
- **Simultaneous press and done on the same floor and edge:** the clear is applied first, then the press. Result: lamp=1, assigned=0, so the floor is re-eligible.
- **Both cars done on the same floor and cycle:** a single clear.
- **FSM IDLE:** go to SELECT when any floor is eligible.
- **FSM SELECT (one cycle):**
  - Floor choice: scan round-robin starting at scan_ptr and take the first eligible floor f.
  - Car eligibility: busy=0 and floor code in 1..5. Codes 0, 6 and 7 make that car ineligible.
  - Car choice: the eligible car with the minimum |carN_floor - f|; on a tie, car 0.
  - If no car is eligible, stay in SELECT and rescan every cycle.
  - If no floor is eligible, go to IDLE.
  - Otherwise register req_floor = f and req_valid = 1 for the chosen car only, and go to OFFER.
- **FSM OFFER:**
  - valid and floor are held stable while ready=0.
  - Transfer occurs on an edge where valid and ready are both 1: set assigned[f], set scan_ptr = f+1 mod 5, drop valid on that edge, go to IDLE.
  - If OFFER_TIMEOUT cycles pass without ready: drop valid, pulse timeout_err for one cycle, leave assigned clear, go to SELECT. The same floor may be re-offered.
  - If floor f is cleared by a done during OFFER: withdraw (valid 0 next cycle), go to SELECT, no timeout_err.
- **Latency:** press at edge k gives SELECT after k+1 and req_valid high after k+2, provided a car is idle.
- **Exclusivity:** at most one carN_req_valid is high at any time.
- **Reset mid-offer:** valid is 0 after the reset edge; all calls are lost.
- **Timeout counter:** 8 bits, saturates, zeroed on entry to OFFER.

Decomposition:
- Shared package elevator_pkg: floor codes FLOOR_1..FLOOR_5 (3'd1..3'd5), NUM_FLOORS, the dispatcher state encoding (IDLE, SELECT, OFFER), and a floor-to-index conversion function.
- Sub-module hall_call_latch: the pending lamp registers and clear logic.
- The dispatcher keeps the FSM, round-robin scan, distance compare and handshake.

Test Plan:
- **Single call:** reset; car0_floor=1, car1_floor=5, both idle; pulse call_up[1] → lamp_up=00010; car0_req_valid=1 with req_floor=2 two cycles later; ready → assigned; car0_done at floor 2 → lamp_up=0.
- **Tie and nearest car:** car0_floor=1, car1_floor=5, call_dn[2] → car0 offered floor 3 (tie). Then car0_floor=2, car1_floor=5, call_dn[3] → car1 offered floor 4.
- **No idle car:** both busy, call_up[0] → FSM stays in SELECT, no valid. Drop car1_busy → car1_req_valid with floor 1 next cycle.
- **Timeout:** ready never asserted → valid drops after 255 cycles, timeout_err pulses once, floor re-offered.
- **Round robin:** calls at floors 1, 3, 5 all pending → offer order 1, 3, 5. Simultaneous press and done on floor 3 → lamp stays 1 and floor 3 is re-offered.
- **Reset during OFFER:** → all outputs 0 on the next edge.
